// File: rtl/adder_1_constructure.sv
// One-bit full adder built from two gate-level half-adder stages, with registered
// copies of the result and a sticky flag that trips if the gates disagree with arithmetic.

module adder_1_constructure_ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  xor u_xor (sum, x, y);
  and u_and (carry, x, y);
endmodule

module adder_1_constructure (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout,
  output logic s_r,
  output logic cout_r,
  output logic err
);
  logic       w_p;
  logic       w_g1;
  logic       w_g2;
  logic       w_s;
  logic       w_cout;
  logic [1:0] w_ref;
  logic       w_ops_known;
  logic       w_mismatch;
  logic       r_s;
  logic       r_cout;
  logic       r_err;

  adder_1_constructure_ha u_ha0 (
    .x     (a),
    .y     (b),
    .sum   (w_p),
    .carry (w_g1)
  );

  adder_1_constructure_ha u_ha1 (
    .x     (w_p),
    .y     (cin),
    .sum   (w_s),
    .carry (w_g2)
  );

  or u_or_cout (w_cout, w_g1, w_g2);

  // Arithmetic reference; the check is skipped whenever an operand is not a clean 0/1.
  assign w_ref       = {1'b0, a} + {1'b0, b} + {1'b0, cin};
  assign w_ops_known = !$isunknown({a, b, cin});
  assign w_mismatch  = w_ops_known && ({w_cout, w_s} != w_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= 1'b0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_cout <= w_cout;
      if (w_mismatch)
        r_err <= 1'b1;
    end
  end

  assign s      = w_s;
  assign cout   = w_cout;
  assign s_r    = r_s;
  assign cout_r = r_cout;
  assign err    = r_err;
endmodule

// File: tb/tb_adder_1_constructure.sv
// Directed and random checks of the structural full adder, its output registers,
// asynchronous reset and the sticky mismatch flag.
`timescale 1ns/1ps

module tb_adder_1_constructure;
  logic clk;
  logic rst;
  logic a;
  logic b;
  logic cin;
  logic s;
  logic cout;
  logic s_r;
  logic cout_r;
  logic err;

  int errors = 0;
  int checks = 0;

  adder_1_constructure dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .s_r    (s_r),
    .cout_r (cout_r),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b0;
    #1;
    checks++;
    if ({s_r, cout_r, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_regs: got s_r=%b cout_r=%b err=%b, want 000", s_r, cout_r, err);
    end
    checks++;
    if ({cout, s} !== 2'b01) begin
      errors++;
      $display("FAIL reset_comb: got cout,s=%b%b, want 01", cout, s);
    end
    $display("reset: a=%b b=%b cin=%b s=%b cout=%b s_r=%b cout_r=%b err=%b", a, b, cin, s, cout, s_r, cout_r, err);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_exhaustive();
    logic [2:0] vec  [8];
    logic [1:0] want [8];
    vec[0] = 3'b010; want[0] = 2'b01;
    vec[1] = 3'b110; want[1] = 2'b10;
    vec[2] = 3'b111; want[2] = 2'b11;
    vec[3] = 3'b000; want[3] = 2'b00;
    vec[4] = 3'b001; want[4] = 2'b01;
    vec[5] = 3'b100; want[5] = 2'b01;
    vec[6] = 3'b011; want[6] = 2'b10;
    vec[7] = 3'b101; want[7] = 2'b10;
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = vec[i];
      #1;
      checks++;
      if ({cout, s} !== want[i]) begin
        errors++;
        $display("FAIL comb_%0d: a,b,cin=%b got cout,s=%b%b want %b", i, vec[i], cout, s, want[i]);
      end else
        $display("comb: a,b,cin=%b cout,s=%b%b", vec[i], cout, s);
    end
  endtask

  task automatic test_random();
    logic [1:0] want;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      want = 2'(a) + 2'(b) + 2'(cin);
      #1;
      checks++;
      if ({cout, s} !== want) begin
        errors++; bad++;
        $display("FAIL random_%0d: a,b,cin=%b%b%b got cout,s=%b%b want %b", i, a, b, cin, cout, s, want);
      end
      #1;
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL random_err: got err=%b, want 0", err);
    end
    $display("random: 1000 vectors, %0d bad, err=%b", bad, err);
  endtask

  task automatic test_latency();
    @(negedge clk);
    a = 1'b0; b = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_r, cout_r} !== 2'b00) begin
      errors++;
      $display("FAIL latency_pre: got s_r,cout_r=%b%b want 00", s_r, cout_r);
    end
    @(negedge clk); #3;
    a = 1'b1; b = 1'b0; cin = 1'b1;
    #1;
    checks++;
    if ({s_r, cout_r} !== 2'b00) begin
      errors++;
      $display("FAIL latency_early: got s_r,cout_r=%b%b before edge, want 00", s_r, cout_r);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_r, cout_r} !== 2'b01) begin
      errors++;
      $display("FAIL latency_edge: got s_r,cout_r=%b%b want 01", s_r, cout_r);
    end
    $display("latency: a,b,cin=101 s_r=%b cout_r=%b", s_r, cout_r);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 1'b1; b = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_r, cout_r} !== 2'b11) begin
      errors++;
      $display("FAIL async_setup: got s_r,cout_r=%b%b want 11", s_r, cout_r);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s_r, cout_r, err} !== 3'b000) begin
      errors++;
      $display("FAIL async_clear: got s_r,cout_r,err=%b%b%b want 000", s_r, cout_r, err);
    end
    a = 1'b0; b = 1'b1; cin = 1'b0;
    #1;
    checks++;
    if ({cout, s} !== 2'b01) begin
      errors++;
      $display("FAIL async_comb: got cout,s=%b%b want 01", cout, s);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_r, cout_r} !== 2'b00) begin
      errors++;
      $display("FAIL async_hold: got s_r,cout_r=%b%b with rst high, want 00", s_r, cout_r);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({s_r, cout_r} !== 2'b00) begin
      errors++;
      $display("FAIL async_release: got s_r,cout_r=%b%b before edge, want 00", s_r, cout_r);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_r, cout_r} !== 2'b10) begin
      errors++;
      $display("FAIL async_resume: got s_r,cout_r=%b%b want 10", s_r, cout_r);
    end
    $display("async_reset: s_r=%b cout_r=%b err=%b", s_r, cout_r, err);
  endtask

  task automatic test_sticky_err();
    @(negedge clk);
    a = 1'b1; b = 1'b0; cin = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL sticky_pre: got err=%b want 0", err);
    end
    force dut.w_g2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got err=%b want 1", err);
    end
    @(negedge clk);
    release dut.w_g2;
    #1;
    checks++;
    if ({cout, s} !== 2'b01) begin
      errors++;
      $display("FAIL sticky_comb: got cout,s=%b%b want 01 after release", cout, s);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: got err=%b want 1", err);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got err=%b want 0", err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL sticky_after: got err=%b want 0", err);
    end
    $display("sticky_err: err=%b", err);
  endtask

  initial begin
    test_reset();
    test_comb_exhaustive();
    test_random();
    test_latency();
    test_async_reset();
    test_sticky_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_1_constructure.md
ADDER_1_CONSTRUCTURE -- requirements
Module: adder_1_constructure

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst  input  1  asynchronous active-high reset for all registered state.
REQ-005 a  input  1  addend bit A.
REQ-006 b  input  1  addend bit B.
REQ-007 cin  input  1  carry-in bit.
REQ-008 s  output  1  combinational sum bit.
REQ-009 cout  output  1  combinational carry-out bit.
REQ-010 s_r  output  1  registered copy of s.
REQ-011 cout_r  output  1  registered copy of cout.
REQ-012 err  output  1  sticky self-check failure flag, registered.

Function
REQ-013 s and cout SHALL be built structurally, using gate instances and not behavioural arithmetic, from two half-adder stages and one OR gate:
- p = a XOR b, g1 = a AND b
- s = p XOR cin, g2 = p AND cin
- cout = g1 OR g2
REQ-014 Each half-adder stage SHALL be a separate submodule instantiated twice; the submodule has inputs x, y and outputs sum (x XOR y) and carry (x AND y).
REQ-015 s and cout SHALL be purely combinational:
- zero clock latency
- independent of clk and rst
- valid for all 8 input combinations, matching {cout,s} = a + b + cin.
REQ-016 s_r and cout_r SHALL capture s and cout on each rising clk edge, giving one-cycle latency.
REQ-017 Each cycle the block SHALL compute a reference value {cout,s} = a + b + cin using 2-bit arithmetic, zero-extending each 1-bit operand.
REQ-018 On any rising edge where the structural {cout,s} differs from the reference value, err SHALL be set to 1.
REQ-019 err SHALL remain 1 until rst is asserted; a later matching cycle SHALL NOT clear it.
REQ-020 If a, b or cin is X/Z, s and cout SHALL propagate X per gate semantics; err SHALL NOT be set on X operands; the comparison is skipped when any operand is not 0/1.
REQ-021 Inputs are asynchronous to clk; registered outputs SHALL reflect whatever input values are stable at the capturing edge.

Reset
REQ-022 While rst=1, s_r, cout_r and err SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-023 While rst=1, s and cout SHALL continue to follow the inputs combinationally.
REQ-024 On rst deassertion, registered outputs SHALL update on the first subsequent rising clk edge.
REQ-025 Asserting rst mid-operation SHALL clear s_r, cout_r and err asynchronously, regardless of their prior values.

Verification
REQ-026 Exhaustive combinational check: a=0,b=1,cin=0 -> s=1,cout=0; a=1,b=1,cin=0 -> s=0,cout=1; a=1,b=1,cin=1 -> s=1,cout=1; a=0,b=0,cin=0 -> s=0,cout=0; cover all 8 combinations within 1 ns of each input change.
REQ-027 Random stimulus: apply random a,b,cin every 2 ns for at least 1000 vectors -> {cout,s} always equals a+b+cin and err stays 0.
REQ-028 Register latency: set a=1,b=0,cin=1 just before a rising edge -> s_r=0, cout_r=1 after that edge, and not before it.
REQ-029 Async reset: with s_r=1, cout_r=1, assert rst between clock edges -> s_r, cout_r and err go to 0 immediately, while s and cout still follow the inputs.
REQ-030 Sticky err: force an internal mismatch for one cycle (e.g., override g2) -> err=1 at the next edge; it stays 1 after the override is released, and clears only on rst=1.
